// File: rtl/dice_bank.sv
// Bank of NUM_DICE odometer-style dice that roll while button is held and publish their sum after a settle delay.
// Optional build macro DICE_BANK_LFSR_EN gates the lowest die's carry with a 16-bit LFSR bit.
module dice_bank #(
    parameter  int NUM_DICE   = 2,
    parameter  int FACES      = 6,
    parameter  int SETTLE_CYC = 4,
    localparam int W          = $clog2(FACES + 1),
    localparam int SW         = $clog2(NUM_DICE * FACES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    input  logic [NUM_DICE-1:0]   hold,
    output logic [NUM_DICE*W-1:0] throws,
    output logic [SW-1:0]         sum,
    output logic                  valid,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | waiting for button
    // ROLL   | dice advance every edge while button is held
    // SETTLE | button released, counting down before publishing
    // DONE   | one cycle: latch sum and raise valid
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [W-1:0]  FACE_MAX    = W'(FACES);
    localparam logic [W-1:0]  FACE_MIN    = W'(1);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SUM_RESET   = SW'(NUM_DICE);

    state_t                     state, state_nxt;
    logic [7:0]                 cnt, cnt_nxt;
    logic [NUM_DICE-1:0][W-1:0] die;
    logic [NUM_DICE-1:0]        adv;
    logic                       carry0;
    logic [SW-1:0]              total;

`ifdef DICE_BANK_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign carry0 = lfsr[0];
`else
    assign carry0 = 1'b1;
`endif

    // Held dice pass their incoming carry straight through to the next die.
    always_comb begin : carry_chain
        logic c;
        c   = carry0;
        adv = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            adv[i] = c && !hold[i];
            if (!hold[i]) begin
                c = c && (die[i] == FACE_MAX);
            end
        end
    end

    always_comb begin : adder
        logic [SW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            acc = acc + SW'(die[i]);
        end
        total = acc;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (button) begin
                    state_nxt = ROLL;
                end
            end
            ROLL: begin
                if (!button) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (button) begin
                    state_nxt = ROLL;
                end else if (cnt == 8'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The edge that leaves ROLL still advances the dice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DICE; i++) begin
                die[i] <= FACE_MIN;
            end
        end else if (state == ROLL) begin
            for (int i = 0; i < NUM_DICE; i++) begin
                if (adv[i]) begin
                    die[i] <= (die[i] == FACE_MAX) ? FACE_MIN : die[i] + FACE_MIN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= SUM_RESET;
            valid <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                sum <= total;
            end
        end
    end

    assign throws = die;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dice_bank.sv
// Directed bench for dice_bank at NUM_DICE=2, FACES=6, SETTLE_CYC=4 (default build).
module tb_dice_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic [1:0] hold = 2'b00;
    logic [5:0] throws;
    logic [3:0] sum;
    logic       valid;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    dice_bank #(.NUM_DICE(2), .FACES(6), .SETTLE_CYC(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .hold   (hold),
        .throws (throws),
        .sum    (sum),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       button;
        logic [1:0] hold;
        logic [5:0] throws;
        logic [3:0] sum;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] pk(input int d1, input int d0);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'(d1);
        b = 3'(d0);
        return {a, b};
    endfunction

    task automatic add(input logic r, input logic b, input logic [1:0] h,
                       input int d1, input int d0, input int s,
                       input logic v, input logic bz);
        vec_t e;
        e.rst    = r;
        e.button = b;
        e.hold   = h;
        e.throws = pk(d1, d0);
        e.sum    = 4'(s);
        e.valid  = v;
        e.busy   = bz;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [5:0] t, input logic [3:0] s,
                             input logic v, input logic bz);
        check({tag, ".throws"}, 32'(throws), 32'(t));
        check({tag, ".sum"},    32'(sum),    32'(s));
        check({tag, ".valid"},  32'(valid),  32'(v));
        check({tag, ".busy"},   32'(busy),   32'(bz));
    endtask

    task automatic reset_pulse();
        rst    = 1'b1;
        button = 1'b0;
        hold   = 2'b00;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int pulse_at;

        // reset, 7 presses, release, settle, publish sum 4
        add(1, 0, 2'b00, 1, 1, 2, 0, 0);
        add(0, 1, 2'b00, 1, 1, 2, 0, 1);
        add(0, 1, 2'b00, 1, 2, 2, 0, 1);
        add(0, 1, 2'b00, 1, 3, 2, 0, 1);
        add(0, 1, 2'b00, 1, 4, 2, 0, 1);
        add(0, 1, 2'b00, 1, 5, 2, 0, 1);
        add(0, 1, 2'b00, 1, 6, 2, 0, 1);
        add(0, 1, 2'b00, 2, 1, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 2, 0, 1);
        add(0, 0, 2'b00, 2, 2, 4, 1, 0);
        add(0, 0, 2'b00, 2, 2, 4, 0, 0);
        // reset, then die0 held while button enters ROLL straight out of reset
        add(1, 0, 2'b00, 1, 1, 2, 0, 0);
        add(0, 1, 2'b01, 1, 1, 2, 0, 1);
        add(0, 1, 2'b01, 2, 1, 2, 0, 1);
        add(0, 1, 2'b01, 3, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 2, 0, 1);
        add(0, 0, 2'b01, 4, 1, 5, 1, 0);
        add(0, 0, 2'b00, 4, 1, 5, 0, 0);
        // die1 held: die0 wraps without carrying into die1
        add(1, 0, 2'b00, 1, 1, 2, 0, 0);
        add(0, 1, 2'b10, 1, 1, 2, 0, 1);
        add(0, 1, 2'b10, 1, 2, 2, 0, 1);
        add(0, 1, 2'b10, 1, 3, 2, 0, 1);
        add(0, 1, 2'b10, 1, 4, 2, 0, 1);
        add(0, 1, 2'b10, 1, 5, 2, 0, 1);
        add(0, 1, 2'b10, 1, 6, 2, 0, 1);
        add(0, 1, 2'b10, 1, 1, 2, 0, 1);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            button = vecs[i].button;
            hold   = vecs[i].hold;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].throws, vecs[i].sum,
                      vecs[i].valid, vecs[i].busy);
        end

        // re-press during SETTLE with counter=2 aborts, later release publishes once
        reset_pulse();
        button = 1'b1;
        step();
        check_all("repress.enter", pk(1, 1), 4'd2, 1'b0, 1'b1);
        button = 1'b0;
        step();
        check_all("repress.release", pk(1, 2), 4'd2, 1'b0, 1'b1);
        step();
        check_all("repress.cnt2", pk(1, 2), 4'd2, 1'b0, 1'b1);
        button = 1'b1;
        step();
        check_all("repress.back_to_roll", pk(1, 2), 4'd2, 1'b0, 1'b1);
        button = 1'b0;
        step();
        check_all("repress.release2", pk(1, 3), 4'd2, 1'b0, 1'b1);
        pulses   = 0;
        pulse_at = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (valid === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
            if (k == 5) begin
                check("repress.sum_at_pulse", 32'(sum), 32'd4);
            end
        end
        check("repress.pulse_count", 32'(pulses), 32'd1);
        check("repress.pulse_edge", 32'(pulse_at), 32'd5);

        // asynchronous reset mid-ROLL at throws (5,3)
        reset_pulse();
        button = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            step();
        end
        check_all("abort.before", pk(3, 5), 4'd2, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("abort.async", pk(1, 1), 4'd2, 1'b0, 1'b0);
        step();
        step();
        check_all("abort.held", pk(1, 1), 4'd2, 1'b0, 1'b0);
        rst    = 1'b0;
        button = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (valid === 1'b1 || busy === 1'b1) begin
                pulses++;
            end
        end
        check("abort.stays_idle", 32'(pulses), 32'd0);
        check_all("abort.final", pk(1, 1), 4'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dice_bank.md
DICE_BANK -- requirements
Module: dice_bank

Interface
REQ-001 Parameter NUM_DICE, default 2: number of dice, legal range 1..8.
REQ-002 Parameter FACES, default 6: faces per die, legal range 2..15; each die shows values 1..FACES.
REQ-003 Parameter SETTLE_CYC, default 4: cycles to wait after button release before the result is published; legal range 1..255.
REQ-004 Derived widths: W = clog2(FACES+1) per die; SW = clog2(NUM_DICE*FACES+1) for the sum.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 button  input  1  roll request; dice roll while high.
REQ-008 hold  input  NUM_DICE  per-die freeze; a held die keeps its value.
REQ-009 throws  output  NUM_DICE*W  packed die values; die i occupies bits [i*W +: W].
REQ-010 sum  output  SW  registered total of all dice at the last published result.
REQ-011 valid  output  1  single-cycle pulse marking a new published result.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ROLL, SETTLE and DONE, all registered.
REQ-014 IDLE -> ROLL on the first edge with button=1; otherwise the FSM stays in IDLE.
REQ-015 ROLL -> SETTLE on the first edge with button=0, loading settle counter = SETTLE_CYC-1.
REQ-016 SETTLE: with button=1 -> ROLL with no result; else counter 0 -> DONE; else the counter decrements.
REQ-017 DONE -> IDLE unconditionally after one cycle; in that cycle valid=1 and sum takes the total of the current throws.
REQ-018 valid SHALL be 1 exactly SETTLE_CYC+1 edges after the edge that sampled button=0 in ROLL, provided no re-press occurs.
REQ-019 Dice SHALL advance only on edges where the FSM is in ROLL, including the edge leaving ROLL; they are frozen in all other states.
REQ-020 Carry chain: carry_in[0]=1; die i advances when carry_in[i]=1 and hold[i]=0.
REQ-021 carry_in[i+1] = hold[i] ? carry_in[i] : (carry_in[i] and die i == FACES); a held die passes its carry through.
REQ-022 Advance rule: die == FACES -> 1; otherwise die + 1. A die SHALL never show 0 or a value above FACES.
REQ-023 hold SHALL be sampled every cycle; a change takes effect on the next edge.
REQ-024 sum SHALL be computed at SW width with no overflow; it holds its value between DONE states.
REQ-025 The sum adder SHALL be combinational over throws, with sum registered only in DONE.
REQ-026 busy = (state != IDLE); busy is combinational from the state register.

Reset
REQ-027 While rst=1: state=IDLE, every die=1, sum=NUM_DICE, valid=0, busy=0, settle counter=0.
REQ-028 Reset asserted in any state, including mid-ROLL or SETTLE, SHALL abort with no valid pulse; after release the FSM waits in IDLE for button.
REQ-029 With button=1 at reset release, ROLL is entered on the first edge after release.

Configuration
REQ-030 Macro DICE_BANK_LFSR_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle in every state, and carry_in[0]=lfsr[0].
REQ-031 Macro DICE_BANK_LFSR_EN undefined: no LFSR is present and carry_in[0]=1 (pure odometer); all other requirements apply unchanged in both builds.

Verification (NUM_DICE=2, FACES=6, SETTLE_CYC=4, macro undefined unless stated)
REQ-032 Reset pulse -> throws=(1,1), sum=2, valid=0, busy=0.
REQ-033 button=1 for 7 edges, then 0 -> throws=(die0=2, die1=2) with die1 stepped on die0's 6->1 wrap; valid pulses once, 5 edges after release, with sum=4; busy falls the next cycle.
REQ-034 hold=2'b01, button=1 for 3 edges -> die0 stays 1, die1 goes 1->4; after settle, sum=5.
REQ-035 Release, then re-press during SETTLE counter=2 -> return to ROLL, no valid pulse; a later release yields exactly one pulse.
REQ-036 rst asserted mid-ROLL with throws=(5,3) -> immediate (1,1), sum=2, state IDLE, no valid.
REQ-037 DICE_BANK_LFSR_EN defined, button=1 for 1000 cycles with random hold -> every die stays in 1..6 on every cycle; held dice stay constant; valid pulses once per release.
